// File: rtl/caravel_ram_wb_ctrl.sv
// Wishbone slave that maps a window of the user address space onto NBANKS
// single-port 32-bit SRAM macros sharing one A/Di/WE bus and a per-bank EN.
module caravel_ram_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          AW        = 11,
  parameter int          NBANKS    = 3,
  parameter int          BW        = 2,
  parameter int          RD_LAT    = 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic [31:0]          wb_dat_o,
  output logic [NBANKS-1:0]    EN,
  output logic [3:0]           WE,
  output logic [31:0]          Di,
  output logic [AW-1:0]        A,
  input  logic [32*NBANKS-1:0] Do
);

  localparam int           HIT_LSB  = AW + BW + 2;
  localparam logic [BW:0]  NBANKS_W = (BW + 1)'(NBANKS);

  typedef enum logic [2:0] {IDLE, ACCESS, RWAIT, ACK, ERR} state_e;

  state_e          state_q;
  logic [BW-1:0]   bank_q;
  logic            rd_q;
  logic [2:0]      cnt_q;

  logic            dec_hit;
  logic [BW-1:0]   dec_bank;
  logic [AW-1:0]   dec_word;
  logic            dec_valid;
  logic            unused_adr_lsb;

  logic [31:0]     do_bank [NBANKS];

  genvar gi;
  generate
    for (gi = 0; gi < NBANKS; gi++) begin : g_do
      assign do_bank[gi] = Do[32*gi +: 32];
    end
  endgenerate

  // Byte offset within the word is irrelevant to a 32-bit macro.
  assign unused_adr_lsb = ^wb_adr_i[1:0];

  always_comb begin
    dec_hit   = (wb_adr_i[31:HIT_LSB] == BASE_ADDR[31:HIT_LSB]);
    dec_bank  = wb_adr_i[AW+BW+1:AW+2];
    dec_word  = wb_adr_i[AW+1:2];
    dec_valid = dec_hit && ({1'b0, dec_bank} < NBANKS_W);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      EN       <= '0;
      WE       <= '0;
      Di       <= '0;
      A        <= '0;
      bank_q   <= '0;
      rd_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          EN       <= '0;
          WE       <= '0;
          if (wb_cyc_i && wb_stb_i) begin
            if (dec_valid) begin
              A       <= dec_word;
              Di      <= wb_dat_i;
              WE      <= wb_we_i ? wb_sel_i : 4'b0000;
              EN      <= NBANKS'(1) << dec_bank;
              bank_q  <= dec_bank;
              rd_q    <= ~wb_we_i;
              state_q <= ACCESS;
            end else begin
              wb_err_o <= 1'b1;
              state_q  <= ERR;
            end
          end
        end
        ACCESS: begin
          // The macro samples EN/WE on this edge, so they drop here regardless.
          EN <= '0;
          WE <= '0;
          if (!wb_cyc_i) begin
            state_q <= IDLE;
          end else if (rd_q) begin
            cnt_q   <= 3'(RD_LAT - 1);
            state_q <= RWAIT;
          end else begin
            wb_ack_o <= 1'b1;
            state_q  <= ACK;
          end
        end
        RWAIT: begin
          if (!wb_cyc_i) begin
            state_q <= IDLE;
          end else if (cnt_q == 3'd0) begin
            wb_dat_o <= do_bank[bank_q];
            wb_ack_o <= 1'b1;
            state_q  <= ACK;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ACK: begin
          wb_ack_o <= 1'b0;
          state_q  <= IDLE;
        end
        ERR: begin
          wb_err_o <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          EN       <= '0;
          WE       <= '0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/caravel_ram_wb_ctrl.md
Name: caravel_ram_wb_ctrl

Overview:
- Parametrised Wishbone-slave controller for a multi-bank SRAM array in the Caravel user area.
- Decodes a user-project address window and selects one of NBANKS single-port 32-bit SRAM macros.
- Drives a shared A/Di/WE bus, with a per-bank EN line and a per-bank Do return.
- Adds over the single-macro adapter: configurable bank count and depth, programmable read latency, error termination for unmapped accesses, and cycle-abort handling.

Parameters:
- BASE_ADDR, 32'h3000_0000: window base; must be aligned to the window size.
- AW, 11: word-address width per bank (2^AW words per bank).
- NBANKS, 3: number of SRAM banks, 1..8.
- BW, 2: bank-select width. Must satisfy 2^BW >= NBANKS.
- RD_LAT, 1: macro read latency in cycles (from EN edge to valid Do), 1..7.

Ports:
- wb_clk_i, in, 1: system clock. Also clocks the macros.
- wb_rst_i, in, 1: asynchronous, active-high reset.
- wb_adr_i, in, 32: byte address.
- wb_dat_i, in, 32: write data.
- wb_sel_i, in, 4: byte lane enables.
- wb_we_i, in, 1: write strobe.
- wb_cyc_i, in, 1: bus cycle.
- wb_stb_i, in, 1: strobe.
- wb_ack_o, out, 1: normal termination.
- wb_err_o, out, 1: error termination.
- wb_dat_o, out, 32: read data.
- EN, out, NBANKS: one-hot bank enable.
- WE, out, 4: byte write enables (shared).
- Di, out, 32: write data to macros (shared).
- A, out, AW: word address (shared).
- Do, in, 32*NBANKS: bank read data. Bank k occupies Do[32k+31:32k].

Behaviour:
- Reset (async, immediate): state=IDLE; wb_ack_o=0, wb_err_o=0, wb_dat_o=0, EN=0, WE=0, Di=0, A=0; latency counter=0.
- Decode:
  - hit when wb_adr_i[31:AW+BW+2] == BASE_ADDR[31:AW+BW+2];
  - bank = wb_adr_i[AW+BW+1:AW+2];
  - word = wb_adr_i[AW+1:2]; wb_adr_i[1:0] is ignored;
  - valid = hit && bank < NBANKS.
- FSM states: IDLE, ACCESS, RWAIT, ACK, ERR.
- IDLE:
  - on cyc&stb with valid: register A=word, Di=wb_dat_i, WE = wb_we_i ? wb_sel_i : 0, EN=onehot(bank); go to ACCESS;
  - on cyc&stb with !valid: go to ERR; EN stays 0;
  - otherwise EN=0 and WE=0.
- ACCESS: lasts exactly 1 cycle (EN high, so the macro samples at the next edge). Then EN=0 and WE=0.
  - Write: go to ACK.
  - Read: load counter=RD_LAT-1 and go to RWAIT.
- RWAIT: decrement the counter each cycle. When it is 0, capture Do[bank] into wb_dat_o and go to ACK.
- ACK: wb_ack_o=1 for exactly one cycle, then go to IDLE. The strobe is not re-sampled while in ACK.
- ERR: wb_err_o=1 for exactly one cycle, then go to IDLE. No macro access occurs.
- Latency (edges from the first edge sampling cyc&stb to the edge that raises ack):
  - write: 2;
  - read: 2+RD_LAT;
  - unmapped: 1.
- Back-to-back: the next request is accepted in IDLE the cycle after ack/err, so peak throughput is one write per 3 cycles.
- wb_dat_o holds the last read value. Writes and errors leave it unchanged.
- Write with wb_sel_i=0: full handshake with WE=0; memory is unmodified; ack is still returned.
- Abort: if wb_cyc_i drops in ACCESS/RWAIT/ACK/ERR, go to IDLE next cycle; ack/err is not asserted (or is cleared); EN/WE are deasserted.
  - A write already presented in ACCESS may have completed in the macro; this is permitted.
- Reset mid-transaction: all outputs clear immediately; no ack is issued after reset.
- wb_ack_o and wb_err_o are never high simultaneously.

Test Plan:
- Write 32'hDEADBEEF to 0x3000_0004 (sel=4'hF), then read it back with RD_LAT=1 -> bank0 A=1 with WE=4'hF for one cycle; write ack at edge 2; read ack at edge 3 with wb_dat_o=32'hDEADBEEF.
- Byte write sel=4'b0100 data 32'h00AA0000 to 0x3000_2008 over a prior 0 -> EN=3'b001? no, bank1 (EN=3'b010), A=2, WE=4'b0100; readback = 32'h00AA0000.
- Read 0x3000_6000 (bank 3, NBANKS=3) and read 0x4000_0000 -> wb_err_o pulses 1 cycle after 1 edge each; EN stays 0; wb_ack_o stays 0.
- RD_LAT=3 build: read of bank 2 -> ack exactly 5 edges after request; wb_dat_o = Do[95:64] sampled in the final RWAIT cycle.
- Drop wb_cyc_i in RWAIT, then issue a new write -> no ack for the aborted read; the new write acks at edge 2 of its own request.
- Assert wb_rst_i in ACCESS of a write -> EN/WE/ack go to 0 without waiting for a clock edge; after release, state is IDLE and wb_dat_o=0.
